// File: rtl/multicycle_ctrl_unit.sv
// ============================================================================
// multicycle_ctrl_unit
// ----------------------------------------------------------------------------
// Control FSM for a multicycle RV32 datapath. It decodes the IR opcode and
// funct3 and drives every mux select and write strobe of the datapath. It
// supports LW, SW, R-type ALU, I-type ALU, BEQ/BNE and JAL, with an optional
// memory ready/wait handshake and a retired-instruction counter.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : an unknown opcode in DECODE enters TRAP. TRAP holds with all
//               strobes low and a sticky illegal_instr=1 until reset.
//   undefined : an unknown opcode retires as a NOP (DECODE -> FETCH with
//               instr_done=1). illegal_instr is tied 0 and TRAP is unreachable.
//
// Parameters
//   MEM_HANDSHAKE : 1 -> FETCH/MEMRD/MEMWR wait for mem_ready; 0 -> 1-cycle memory
//   INSTRET_W     : width of the retired-instruction counter
//
// Ports
//   clk, reset              : rising-edge clock, async active-high reset
//   opcode, funct3          : IR[6:0], IR[14:12] (funct3[0] = BNE when 1)
//   mem_ready               : memory completes the current access this cycle
//   RegWrite .. ALUSrcA     : 1-bit datapath controls
//   BranchNe                : invert the zero flag for the conditional PC write
//   ALUOp, ALUSrcB          : ALU operation class / operand B select
//   MemtoReg, PCSource      : register write-back source / PC source select
//   instr_done              : 1-cycle pulse in the last cycle of each instruction
//   instret                 : count of instr_done pulses (wraps)
//   illegal_instr           : sticky illegal-opcode flag (0 if feature off)
//   state_o                 : current state encoding, for debug
// ============================================================================
module multicycle_ctrl_unit #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int INSTRET_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 mem_ready,
    output logic                 RegWrite,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 PCWriteCond,
    output logic                 IorD,
    output logic                 ALUSrcA,
    output logic                 BranchNe,
    output logic [1:0]           ALUOp,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           MemtoReg,
    output logic [1:0]           PCSource,
    output logic                 instr_done,
    output logic [INSTRET_W-1:0] instret,
    output logic                 illegal_instr,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_ALUWB  = 4'd7,
        S_EXEC_I = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    state_t state, next_state;
    logic   rdy;
    logic   is_lw, is_sw, is_r, is_i, is_br, is_jal, is_known;

    // Only funct3[0] (BEQ/BNE) matters to control; the other bits go to the ALU control.
    logic   unused_funct3;
    assign unused_funct3 = ^funct3[2:1];

    // With the handshake disabled memory is treated as always ready.
    assign rdy = mem_ready | !MEM_HANDSHAKE;

    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_br    = (opcode == OP_BRANCH);
    assign is_jal   = (opcode == OP_JAL);
    assign is_known = is_lw | is_sw | is_r | is_i | is_br | is_jal;

    assign state_o = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = S_FETCH;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        ALUSrcA     = 1'b0;
        BranchNe    = 1'b0;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        MemtoReg    = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;

        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // IR and PC+4 are captured only in the cycle memory delivers the word.
                IRWrite = rdy;
                PCWrite = rdy;
                next_state = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Speculatively compute PC+imm into ALUOut for branch/jump targets.
                ALUSrcB = 2'b10;
                if (is_lw || is_sw) begin
                    next_state = S_MEMADR;
                end else if (is_r) begin
                    next_state = S_EXEC_R;
                end else if (is_i) begin
                    next_state = S_EXEC_I;
                end else if (is_br) begin
                    next_state = S_BRANCH;
                end else if (is_jal) begin
                    next_state = S_JAL;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    next_state = S_TRAP;
`else
                    next_state = S_FETCH;
                    instr_done = 1'b1;
`endif
                end
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = is_lw ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                next_state = rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b01;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = rdy;
                next_state = rdy ? S_FETCH : S_MEMWR;
            end
            S_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                next_state = S_ALUWB;
            end
            S_EXEC_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = 2'b11;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNe    = funct3[0];
                instr_done  = 1'b1;
                next_state  = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value.
                RegWrite   = 1'b1;
                MemtoReg   = 2'b10;
                PCWrite    = 1'b1;
                PCSource   = 2'b01;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                next_state = S_TRAP;
`else
                next_state = S_FETCH;
`endif
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        // No architectural state may be written while reset is held.
        if (reset) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret <= '0;
        end else if (instr_done) begin
            instret <= instret + INSTRET_ONE;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_instr <= 1'b0;
        end else if (state == S_DECODE && !is_known) begin
            illegal_instr <= 1'b1;
        end
    end
`else
    assign illegal_instr = 1'b0;
`endif

endmodule
